cache_controller: RTL and testbench

Sequencing FSM for the cache/memory datapath. It turns CPU load/store requests into the datapath's control strobes: `cache_we`, `cache_in_select`, `mem_in_select` and the cache `is_byte`, plus a memory write enable. Hits complete in one cycle; misses perform a dirty-line writeback and a line fill, each against a fixed-latency main memory. It sits between the core's memory stage and the cache datapath, and stalls the core until each access completes.

---
 rtl/cache_controller_if.sv | 33 +++
 rtl/cache_controller.sv | 123 ++++++++++++
 tb/tb_cache_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cache_controller_if.sv
// CPU/datapath side of the cache sequencing controller: requests, lookup status,
// datapath strobes and performance counters.
interface cache_controller_if #(
   parameter int CNT_W = 16
);
   logic             rd_req;
   logic             wr_req;
   logic             cpu_is_byte;
   logic             hit;
   logic             dirty_bit;
   logic             cache_we;
   logic             cache_in_select;
   logic             mem_in_select;
   logic             cache_is_byte;
   logic             mem_we;
   logic             done;
   logic             stall;
   logic             busy;
   logic [CNT_W-1:0] miss_count;
   logic [CNT_W-1:0] wb_count;

   modport slave (
      input  rd_req, wr_req, cpu_is_byte, hit, dirty_bit,
      output cache_we, cache_in_select, mem_in_select, cache_is_byte, mem_we,
             done, stall, busy, miss_count, wb_count
   );

   modport master (
      output rd_req, wr_req, cpu_is_byte, hit, dirty_bit,
      input  cache_we, cache_in_select, mem_in_select, cache_is_byte, mem_we,
             done, stall, busy, miss_count, wb_count
   );
endinterface

// File: rtl/cache_controller.sv
// Sequencing FSM turning CPU loads/stores into cache datapath strobes, with
// dirty-line writeback and line fill against a fixed-latency main memory.
//
// state  | meaning
// IDLE   | lookup; hits complete this cycle, misses start WB or FILL
// WB     | victim line written to memory for MEM_LATENCY cycles
// FILL   | line read from memory; written into cache on the last cycle
module cache_controller #(
   parameter int MEM_LATENCY = 4,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst_b,
   cache_controller_if.slave    bus
);
   localparam int            CW     = $clog2(MEM_LATENCY) + 1;
   localparam logic [CW-1:0] CNT_LD = CW'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WB   = 2'd1,
      S_FILL = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] miss_q, miss_d;
   logic [CNT_W-1:0] wb_q, wb_d;

   logic req;
   logic cache_we, cache_in_select, mem_in_select, cache_is_byte, mem_we, done;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         miss_q  <= '0;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         miss_q  <= miss_d;
         wb_q    <= wb_d;
      end
   end

   always_comb begin
      req             = bus.rd_req | bus.wr_req;
      state_d         = state_q;
      cnt_d           = cnt_q;
      miss_d          = miss_q;
      wb_d            = wb_q;
      cache_we        = 1'b0;
      cache_in_select = 1'b1;
      mem_in_select   = 1'b0;
      cache_is_byte   = bus.cpu_is_byte;
      mem_we          = 1'b0;
      done            = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (bus.hit) begin
                  // a simultaneous rd/wr request resolves to a store
                  done     = 1'b1;
                  cache_we = bus.wr_req;
               end else begin
                  miss_d  = miss_q + CNT_W'(1);
                  cnt_d   = CNT_LD;
                  state_d = bus.dirty_bit ? S_WB : S_FILL;
               end
            end
         end
         S_WB: begin
            mem_in_select = 1'b1;
            mem_we        = 1'b1;
            if (cnt_q == '0) begin
               state_d = S_FILL;
               cnt_d   = CNT_LD;
               wb_d    = wb_q + CNT_W'(1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_FILL: begin
            if (cnt_q == '0) begin
               // full-word fill; the re-lookup in IDLE completes the access
               cache_we        = 1'b1;
               cache_in_select = 1'b0;
               cache_is_byte   = 1'b0;
               state_d         = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // outputs are Mealy, so reset must mask them directly
      if (!rst_b) begin
         cache_we        = 1'b0;
         cache_in_select = 1'b1;
         mem_in_select   = 1'b0;
         cache_is_byte   = 1'b0;
         mem_we          = 1'b0;
         done            = 1'b0;
      end
   end

   assign bus.cache_we        = cache_we;
   assign bus.cache_in_select = cache_in_select;
   assign bus.mem_in_select   = mem_in_select;
   assign bus.cache_is_byte   = cache_is_byte;
   assign bus.mem_we          = mem_we;
   assign bus.done            = done;
   assign bus.stall           = rst_b & req & ~done;
   assign bus.busy            = rst_b & (state_q != S_IDLE);
   assign bus.miss_count      = miss_q;
   assign bus.wb_count        = wb_q;
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: MEM_LATENCY=4 instance for the main
// sequences, MEM_LATENCY=1 / CNT_W=2 instance for short misses and counter wrap.
module tb_cache_controller;
   logic clk;
   logic rst_b;

   cache_controller_if #(.CNT_W(16)) if_a ();
   cache_controller_if #(.CNT_W(2))  if_b ();

   cache_controller #(.MEM_LATENCY(4), .CNT_W(16)) dut_a (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (if_a.slave)
   );

   cache_controller #(.MEM_LATENCY(1), .CNT_W(2)) dut_b (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (if_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         nvec = 0;
   int         errs = 0;
   logic [7:0] exp_q[$];

   // {cache_we, cache_in_select, mem_in_select, cache_is_byte, mem_we, done, stall, busy}
   function automatic logic [7:0] obs(input bit sel);
      if (!sel)
         return {if_a.cache_we, if_a.cache_in_select, if_a.mem_in_select, if_a.cache_is_byte,
                 if_a.mem_we, if_a.done, if_a.stall, if_a.busy};
      else
         return {if_b.cache_we, if_b.cache_in_select, if_b.mem_in_select, if_b.cache_is_byte,
                 if_b.mem_we, if_b.done, if_b.stall, if_b.busy};
   endfunction

   task automatic drive(input bit sel, input bit rd, input bit wr, input bit byt,
                        input bit hit, input bit dirty);
      if (!sel) begin
         if_a.rd_req = rd; if_a.wr_req = wr; if_a.cpu_is_byte = byt;
         if_a.hit = hit;   if_a.dirty_bit = dirty;
      end else begin
         if_b.rd_req = rd; if_b.wr_req = wr; if_b.cpu_is_byte = byt;
         if_b.hit = hit;   if_b.dirty_bit = dirty;
      end
   endtask

   task automatic compare(input bit sel, input string tag);
      logic [7:0] got, e;
      got = obs(sel);
      e   = exp_q.pop_front();
      nvec++;
      assert (got === e) else begin
         errs++;
         $error("FAIL %s observed=%b expected=%b", tag, got, e);
      end
   endtask

   // one clock cycle: drive at negedge, check combinational outputs 2ns later
   task automatic step(input bit sel, input bit rd, input bit wr, input bit byt,
                       input bit hit, input bit dirty, input logic [7:0] e, input string tag);
      @(negedge clk);
      drive(sel, rd, wr, byt, hit, dirty);
      exp_q.push_back(e);
      #2;
      compare(sel, tag);
   endtask

   task automatic chk_cnt(input logic [15:0] got, input logic [15:0] e, input string tag);
      nvec++;
      assert (got === e) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, e);
      end
   endtask

   initial begin
      rst_b = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);

      // reset masks the Mealy hit path
      step(0, 1, 0, 1, 1, 0, 8'b0100_0000, "reset_outputs");
      chk_cnt(if_a.miss_count, 16'd0, "reset_miss_count");
      chk_cnt(if_a.wb_count,   16'd0, "reset_wb_count");
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      rst_b = 1'b1;

      // back-to-back hits
      step(0, 1, 0, 0, 1, 0, 8'b0100_0100, "read_hit");
      step(0, 0, 1, 1, 1, 0, 8'b1101_0100, "store_hit_byte");
      step(0, 1, 1, 0, 1, 1, 8'b1100_0100, "rd_wr_hit_is_store");

      // clean read miss, byte access; hit asserted mid-fill must be ignored
      step(0, 1, 0, 1, 0, 0, 8'b0101_0010, "clean_c0");
      step(0, 1, 0, 1, 0, 0, 8'b0101_0011, "clean_c1");
      step(0, 1, 0, 1, 1, 0, 8'b0101_0011, "clean_c2");
      step(0, 1, 0, 1, 0, 1, 8'b0101_0011, "clean_c3");
      step(0, 1, 0, 1, 0, 0, 8'b1000_0011, "clean_c4_fill");
      step(0, 1, 0, 1, 1, 0, 8'b0101_0100, "clean_c5_done");
      chk_cnt(if_a.miss_count, 16'd1, "clean_miss_count");
      chk_cnt(if_a.wb_count,   16'd0, "clean_wb_count");

      // dirty store miss
      step(0, 0, 1, 0, 0, 1, 8'b0100_0010, "dirty_c0");
      for (int c = 1; c <= 4; c++)
         step(0, 0, 1, 0, 0, 0, 8'b0110_1011, $sformatf("dirty_wb_c%0d", c));
      for (int c = 5; c <= 7; c++)
         step(0, 0, 1, 0, 0, 0, 8'b0100_0011, $sformatf("dirty_fill_c%0d", c));
      step(0, 0, 1, 0, 0, 0, 8'b1000_0011, "dirty_c8_fill");
      step(0, 0, 1, 0, 1, 0, 8'b1100_0100, "dirty_c9_done");
      chk_cnt(if_a.miss_count, 16'd2, "dirty_miss_count");
      chk_cnt(if_a.wb_count,   16'd1, "dirty_wb_count");

      // request dropped during fill: fill completes, no done
      step(0, 1, 0, 0, 0, 0, 8'b0100_0010, "drop_c0");
      step(0, 1, 0, 0, 0, 0, 8'b0100_0011, "drop_c1");
      step(0, 0, 0, 0, 0, 0, 8'b0100_0001, "drop_c2");
      step(0, 0, 0, 0, 1, 0, 8'b0100_0001, "drop_c3");
      step(0, 0, 0, 0, 0, 0, 8'b1000_0001, "drop_c4_fill");
      step(0, 0, 0, 0, 1, 0, 8'b0100_0000, "drop_c5_idle");
      chk_cnt(if_a.miss_count, 16'd3, "drop_miss_count");

      // asynchronous reset in the middle of a writeback
      step(0, 0, 1, 0, 0, 1, 8'b0100_0010, "rstwb_c0");
      step(0, 0, 1, 0, 0, 1, 8'b0110_1011, "rstwb_c1");
      @(negedge clk);
      #1 rst_b = 1'b0;
      exp_q.push_back(8'b0100_0000);
      #1;
      compare(0, "rstwb_async");
      chk_cnt(if_a.miss_count, 16'd0, "rstwb_miss_count");
      chk_cnt(if_a.wb_count,   16'd0, "rstwb_wb_count");
      #1;
      drive(0, 0, 0, 0, 0, 0);
      rst_b = 1'b1;
      step(0, 0, 0, 0, 0, 0, 8'b0100_0000, "rstwb_idle_after");

      // MEM_LATENCY=1: dirty miss completes at cycle 3
      step(1, 0, 1, 0, 0, 1, 8'b0100_0010, "ml1_c0");
      step(1, 0, 1, 0, 0, 0, 8'b0110_1011, "ml1_c1_wb");
      step(1, 0, 1, 0, 0, 0, 8'b1000_0011, "ml1_c2_fill");
      step(1, 0, 1, 0, 1, 0, 8'b1100_0100, "ml1_c3_done");
      chk_cnt(16'(if_b.wb_count), 16'd1, "ml1_wb_count");

      // 2-bit miss counter wraps after four misses
      for (int m = 2; m <= 4; m++) begin
         step(1, 1, 0, 0, 0, 0, 8'b0100_0010, $sformatf("wrap%0d_c0", m));
         step(1, 1, 0, 0, 0, 0, 8'b1000_0011, $sformatf("wrap%0d_fill", m));
         step(1, 1, 0, 0, 1, 0, 8'b0100_0100, $sformatf("wrap%0d_done", m));
         chk_cnt(16'(if_b.miss_count), 16'(m % 4), $sformatf("wrap%0d_miss_count", m));
      end
      step(1, 0, 0, 0, 0, 0, 8'b0100_0000, "ml1_idle");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end
endmodule
